// File: rtl/key_range_ctrl_if.sv
// Link between the key front end and the Collatz range block.
interface key_range_ctrl_if;
  logic        go;
  logic [31:0] start;
  logic [11:0] n;
  logic        busy;
  logic        done;

  modport master (output go, start, n, busy, input done);
  modport slave  (input go, start, n, busy, output done);
endinterface

// File: rtl/key_range_ctrl.sv
// Pushbutton front end: per-key sync/debounce/auto-repeat lanes feeding a
// two-state launch FSM that owns go/start/n/busy.
module key_range_db #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000,
  parameter bit REPEAT          = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic press,
  output logic rep
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);

  logic [1:0]    sync;
  logic          stable;
  logic [DW-1:0] db_cnt;
  logic [RW-1:0] rep_cnt;
  logic          repeating;
  logic          flip;
  logic          rel;

  assign flip = (sync[1] != stable) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign rel  = flip && sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync      <= 2'b11;
      stable    <= 1'b1;
      db_cnt    <= '0;
      press     <= 1'b0;
      rep       <= 1'b0;
      rep_cnt   <= '0;
      repeating <= 1'b0;
    end else begin
      sync  <= {sync[0], key_raw};
      press <= 1'b0;
      rep   <= 1'b0;
      if (sync[1] != stable) begin
        if (flip) begin
          stable <= sync[1];
          db_cnt <= '0;
          press  <= ~sync[1];
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
      // A release accepted this edge suppresses any repeat due on the same edge.
      if (!REPEAT || stable || rel) begin
        rep_cnt   <= '0;
        repeating <= 1'b0;
      end else if (rep_cnt == (repeating ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1))) begin
        rep       <= 1'b1;
        repeating <= 1'b1;
        rep_cnt   <= '0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end
endmodule

module key_range_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000,
  parameter int N_WORDS         = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              KEY,
  input  logic [9:0]              SW,
  key_range_ctrl_if.master        rng
);
  localparam int NUM_KEYS = 4;
  localparam int AW = $clog2(N_WORDS);

  typedef enum logic {IDLE, RUN} state_t;

  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] rep;
  logic [NUM_KEYS-1:0] act;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_range_db #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .REPEAT         (k < 2)
    ) u_key (
      .clk    (clk),
      .reset  (reset),
      .key_raw(KEY[k]),
      .press  (press[k]),
      .rep    (rep[k])
    );
  end

  assign act = press | rep;

  state_t        state_q, state_d;
  logic          go_q, go_d;
  logic          busy_q;
  logic [31:0]   start_q, start_d;
  logic [AW-1:0] n_q, n_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      busy_q  <= (state_d == RUN);
      start_q <= start_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    go_d    = 1'b0;
    start_d = start_q;
    n_d     = n_q;
    case (state_q)
      IDLE: begin
        if (act[3]) begin
          go_d    = 1'b1;
          start_d = {22'b0, SW};
          n_d     = '0;
          state_d = RUN;
        end else if (act[2]) begin
          n_d = '0;
        end else if (act[0] && !act[1]) begin
          n_d = n_q + 1'b1;
        end else if (act[1] && !act[0]) begin
          n_d = n_q - 1'b1;
        end
      end
      RUN: begin
        // done coinciding with the go pulse belongs to no run yet.
        if (rng.done && !go_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rng.go    = go_q;
  assign rng.start = start_q;
  assign rng.n     = 12'(n_q);
  assign rng.busy  = busy_q;
endmodule

// File: tb/tb_key_range_ctrl.sv
// Directed bench with a cycle-level behavioural model checked every cycle.
module tb_key_range_ctrl;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam int NW = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] KEY;
  logic [9:0] SW;

  key_range_ctrl_if rng();

  key_range_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .N_WORDS        (NW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .KEY  (KEY),
    .SW   (SW),
    .rng  (rng)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw sample history per edge since reset; a key's debounced level
  // flips when the D samples ending two edges back all disagree with it.
  logic [3:0] hist [0:4095];
  int         cyc;
  bit  [3:0]  st;
  bit  [3:0]  pf;
  int         pe [4];
  bit         mdl_ok = 1'b0;
  bit         m_go, m_run;
  int         m_n;
  logic [31:0] m_start;

  always @(posedge clk) begin
    bit [3:0] act;
    if (reset) begin
      cyc = 0; st = 4'hF; pf = 4'h0;
      for (int k = 0; k < 4; k++) pe[k] = 0;
      m_go = 0; m_run = 0; m_n = 0; m_start = '0; mdl_ok = 1'b1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        act[k] = pf[k];
        if (k < 2 && !st[k] && !pf[k]) begin
          int d;
          d = cyc - pe[k];
          if (d == RD || (d > RD && (d - RD) % RR == 0)) act[k] = 1'b1;
        end
      end
      if (!m_run) begin
        if (act[3]) begin
          m_go = 1; m_start = {22'b0, SW}; m_n = 0; m_run = 1;
        end else begin
          m_go = 0;
          if (act[2]) m_n = 0;
          else if (act[0] && !act[1]) m_n = (m_n + 1) % NW;
          else if (act[1] && !act[0]) m_n = (m_n + NW - 1) % NW;
        end
      end else begin
        if (rng.done && !m_go) m_run = 0;
        m_go = 0;
      end
      if (cyc < 4095) cyc++;
      hist[cyc] = KEY;
      for (int k = 0; k < 4; k++) begin
        bit flip;
        pf[k] = 0;
        flip = 1;
        for (int j = cyc - D - 1; j <= cyc - 2; j++) begin
          bit v;
          v = (j >= 1) ? hist[j][k] : 1'b1;
          if (v == st[k]) flip = 0;
        end
        if (flip) begin
          st[k] = ~st[k];
          if (!st[k]) begin pf[k] = 1; pe[k] = cyc; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("go",    32'(rng.go),   32'(m_go));
      chk("busy",  32'(rng.busy), 32'(m_run));
      chk("n",     32'(rng.n),    32'(m_n));
      chk("start", rng.start,     m_start);
    end
  end

  task automatic wait_n(int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic press(int k, int hold, int gap);
    KEY[k] = 1'b0;
    wait_n(hold);
    KEY[k] = 1'b1;
    wait_n(gap);
  endtask

  task automatic launch(string tag);
    int go_at, go_cnt;
    go_at = 0; go_cnt = 0;
    KEY[3] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      wait_n(1);
      if (rng.go) begin
        go_cnt++;
        if (go_at == 0) go_at = i;
      end
    end
    KEY[3] = 1'b1;
    chk({tag, "_go_latency"}, 32'(go_at), 32'd7);
    chk({tag, "_go_width"}, 32'(go_cnt), 32'd1);
    chk({tag, "_busy"}, 32'(rng.busy), 32'd1);
    wait_n(10);
  endtask

  int obs [0:60];

  initial begin
    KEY = 4'hF; SW = '0; rng.done = 1'b0; reset = 1'b1;
    wait_n(2);
    reset = 1'b0;

    // 1: idle, nothing pressed
    wait_n(50);
    chk("t1_go", 32'(rng.go), 32'd0);
    chk("t1_n", 32'(rng.n), 32'd0);
    chk("t1_busy", 32'(rng.busy), 32'd0);
    chk("t1_start", rng.start, 32'd0);

    // 2: clean launch, SW moves during run, done pulse
    SW = 10'h01B;
    launch("t2");
    chk("t2_start", rng.start, 32'h1B);
    SW = 10'h3FF;
    wait_n(10);
    chk("t2_start_hold", rng.start, 32'h1B);
    rng.done = 1'b1;
    chk("t2_busy_pre_done", 32'(rng.busy), 32'd1);
    wait_n(1);
    rng.done = 1'b0;
    chk("t2_busy_post_done", 32'(rng.busy), 32'd0);
    wait_n(5);

    // 3: bouncing KEY[0] then solid press
    for (int g = 0; g < 3; g++) begin
      KEY[0] = 1'b0; wait_n(1);
      KEY[0] = 1'b1; wait_n(2);
    end
    press(0, 10, 10);
    chk("t3_n", 32'(rng.n), 32'd1);

    // 4: hold KEY[1] from n=0 with auto-repeat
    press(2, 8, 10);
    chk("t4_clear", 32'(rng.n), 32'd0);
    KEY[1] = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      wait_n(1);
      obs[i] = int'(rng.n);
      if (i == 42) KEY[1] = 1'b1;
    end
    chk("t4_n6", 32'(obs[6]), 32'd0);
    chk("t4_n7", 32'(obs[7]), 32'd255);
    chk("t4_n26", 32'(obs[26]), 32'd255);
    chk("t4_n27", 32'(obs[27]), 32'd254);
    chk("t4_n32", 32'(obs[32]), 32'd253);
    chk("t4_n47", 32'(obs[47]), 32'd250);
    chk("t4_n60", 32'(obs[60]), 32'd250);
    wait_n(5);

    // 5: clear beats step; keys ignored in RUN
    press(2, 8, 10);
    repeat (5) press(0, 8, 10);
    chk("t5_n5", 32'(rng.n), 32'd5);
    KEY[2] = 1'b0; KEY[0] = 1'b0;
    wait_n(8);
    KEY = 4'hF;
    wait_n(10);
    chk("t5_clear_wins", 32'(rng.n), 32'd0);
    SW = 10'h2A5;
    launch("t5");
    chk("t5_start", rng.start, 32'h2A5);
    press(0, 8, 10);
    press(1, 8, 10);
    press(3, 8, 10);
    chk("t5_run_n", 32'(rng.n), 32'd0);
    chk("t5_run_busy", 32'(rng.busy), 32'd1);
    rng.done = 1'b1; wait_n(1); rng.done = 1'b0;
    chk("t5_idle", 32'(rng.busy), 32'd0);

    // 6: reset mid-run
    repeat (3) press(0, 8, 10);
    chk("t6_n3", 32'(rng.n), 32'd3);
    SW = 10'h155;
    launch("t6");
    reset = 1'b1;
    wait_n(1);
    reset = 1'b0;
    chk("t6_rst_busy", 32'(rng.busy), 32'd0);
    chk("t6_rst_start", rng.start, 32'd0);
    chk("t6_rst_n", 32'(rng.n), 32'd0);
    wait_n(2);
    rng.done = 1'b1; wait_n(1); rng.done = 1'b0;
    wait_n(2);
    chk("t6_done_ignored", 32'(rng.busy), 32'd0);
    SW = 10'h0C3;
    launch("t6b");
    chk("t6b_start", rng.start, 32'hC3);
    rng.done = 1'b1; wait_n(1); rng.done = 1'b0;
    wait_n(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
